// File: rtl/riscv_v_issue_queue.sv
// In-order vector instruction buffer between scalar-core issue and vector decode.
// Optional same-cycle empty-queue bypass compiled in with RISCV_V_ISSUE_BYPASS_EN.
module riscv_v_issue_queue #(
  parameter int unsigned            DEPTH       = 4,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_pipe,
  input  logic                         enq_valid,
  input  logic [INSTR_WIDTH-1:0]       enq_instr,
  input  logic [DATA_WIDTH-1:0]        enq_int_data,
  output logic                         enq_ready,
  input  logic                         riscv_v_stall,
  output logic [INSTR_WIDTH-1:0]       instruction_id,
  output logic [DATA_WIDTH-1:0]        int_rf_rd_data_id,
  output logic                         instr_valid_id,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  r_data_mem  [DEPTH];
  logic [PW-1:0]          r_wp;
  logic [PW-1:0]          r_rp;
  logic [CW-1:0]          r_count;
  logic                   r_overflow;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_enq;
  logic                   w_write;
  logic                   w_deq;
  logic [INSTR_WIDTH-1:0] w_head_instr;
  logic [DATA_WIDTH-1:0]  w_head_data;
  logic                   w_head_valid;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_enq   = enq_valid && !w_full;
  assign w_deq   = !w_empty && !riscv_v_stall;

`ifdef RISCV_V_ISSUE_BYPASS_EN
  // An unstalled bypassed instruction is consumed straight from the inputs and never stored.
  assign w_write = w_enq && !(w_empty && !riscv_v_stall);
`else
  assign w_write = w_enq;
`endif

  always_comb begin
    w_head_instr = NOP_INSTR;
    w_head_data  = '0;
    w_head_valid = 1'b0;
    if (!w_empty) begin
      w_head_instr = r_instr_mem[r_rp];
      w_head_data  = r_data_mem[r_rp];
      w_head_valid = 1'b1;
    end
`ifdef RISCV_V_ISSUE_BYPASS_EN
    else if (enq_valid && !clear_pipe) begin
      w_head_instr = enq_instr;
      w_head_data  = enq_int_data;
      w_head_valid = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (enq_valid && w_full) r_overflow <= 1'b1;
      if (clear_pipe) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_count <= '0;
      end else begin
        if (w_write) r_wp <= r_wp + PW'(1);
        if (w_deq)   r_rp <= r_rp + PW'(1);
        if (w_write && !w_deq)      r_count <= r_count + CW'(1);
        else if (!w_write && w_deq) r_count <= r_count - CW'(1);
      end
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (!rst && !clear_pipe && w_write) begin
      r_instr_mem[r_wp] <= enq_instr;
      r_data_mem[r_wp]  <= enq_int_data;
    end
  end

  assign enq_ready         = !w_full;
  assign full              = w_full;
  assign empty             = w_empty;
  assign count             = r_count;
  assign overflow_err      = r_overflow;
  assign instruction_id    = w_head_instr;
  assign int_rf_rd_data_id = w_head_data;
  assign instr_valid_id    = w_head_valid;

endmodule

// File: tb/tb_riscv_v_issue_queue.sv
// Directed self-checking bench for riscv_v_issue_queue (default DEPTH=4).
// Bypass expectations are selected with RISCV_V_ISSUE_BYPASS_EN, matching the DUT build.
module tb_riscv_v_issue_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear_pipe = 1'b0;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_instr = '0;
  logic [31:0] enq_int_data = '0;
  logic        enq_ready;
  logic        riscv_v_stall = 1'b0;
  logic [31:0] instruction_id;
  logic [31:0] int_rf_rd_data_id;
  logic        instr_valid_id;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow_err;

  int checks = 0;
  int failures = 0;

  riscv_v_issue_queue dut (
    .clk               (clk),
    .rst               (rst),
    .clear_pipe        (clear_pipe),
    .enq_valid         (enq_valid),
    .enq_instr         (enq_instr),
    .enq_int_data      (enq_int_data),
    .enq_ready         (enq_ready),
    .riscv_v_stall     (riscv_v_stall),
    .instruction_id    (instruction_id),
    .int_rf_rd_data_id (int_rf_rd_data_id),
    .instr_valid_id    (instr_valid_id),
    .count             (count),
    .full              (full),
    .empty             (empty),
    .overflow_err      (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear_pipe = 1'b0; enq_valid = 1'b0; riscv_v_stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL reset_enq_ready got=%0b exp=1", enq_ready); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (instruction_id !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instruction_id, NOP); end
    checks++; if (int_rf_rd_data_id !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", int_rf_rd_data_id); end
    checks++; if (instr_valid_id !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", instr_valid_id); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow_err); end
  endtask

  task automatic test_fill_order();
    do_reset();
    riscv_v_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      enq_valid = 1'b1; enq_instr = 32'h0000_1057 + k; enq_int_data = k;
      tick();
    end
    enq_valid = 1'b0;
    #1;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", full); end
    checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL fill_enq_ready got=%0b exp=0", enq_ready); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
    tick();
    checks++; if (instruction_id !== 32'h0000_1057) begin failures++; $display("FAIL fill_stall_hold got=%h exp=00001057", instruction_id); end
    riscv_v_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (instruction_id !== 32'h0000_1057 + k || int_rf_rd_data_id !== k || instr_valid_id !== 1'b1) begin
        failures++;
        $display("FAIL order_head%0d got=%h/%h/%0b exp=%h/%h/1", k, instruction_id, int_rf_rd_data_id,
                 instr_valid_id, 32'h0000_1057 + k, k);
      end
      tick();
    end
    checks++; if (empty !== 1'b1 || instr_valid_id !== 1'b0 || instruction_id !== NOP) begin
      failures++; $display("FAIL order_drained got=empty%0b/valid%0b/%h exp=1/0/%h", empty, instr_valid_id, instruction_id, NOP);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_q [$];
    do_reset();
    riscv_v_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      enq_valid = 1'b1; enq_instr = 32'h0000_A057 + k; enq_int_data = 32'h100 + k;
      exp_q.push_back(32'h0000_A057 + k);
      tick();
    end
    enq_instr = 32'hDEAD_0057; enq_int_data = 32'hDEAD;
    tick();
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
    checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow_err); end
    checks++; if (instruction_id !== 32'h0000_A057) begin failures++; $display("FAIL ovf_head got=%h exp=0000a057", instruction_id); end
    // Full with a simultaneous dequeue: refused now, accepted next cycle.
    riscv_v_stall = 1'b0; enq_instr = 32'hBEEF_0057; enq_int_data = 32'hBEEF;
    #1;
    checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL ovf_deq_ready got=%0b exp=0", enq_ready); end
    tick();
    void'(exp_q.pop_front());
    checks++; if (count !== 3'd3 || enq_ready !== 1'b1) begin failures++; $display("FAIL ovf_deq_refused got=%0d/%0b exp=3/1", count, enq_ready); end
    tick();
    void'(exp_q.pop_front());
    exp_q.push_back(32'hBEEF_0057);
    enq_valid = 1'b0;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL ovf_accept_next got=%0d exp=3", count); end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (instruction_id !== exp_q[k]) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", k, instruction_id, exp_q[k]); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_drained got=%0b exp=1", empty); end
    clear_pipe = 1'b1;
    tick();
    clear_pipe = 1'b0;
    checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky_clear got=%0b exp=1", overflow_err); end
    // Reset while full and stalled.
    riscv_v_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      enq_valid = 1'b1; enq_instr = 32'h0000_C057 + k; enq_int_data = k;
      tick();
    end
    enq_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || empty !== 1'b1 || overflow_err !== 1'b0 || instr_valid_id !== 1'b0 || instruction_id !== NOP) begin
      failures++; $display("FAIL midreset got=cnt%0d/empty%0b/ovf%0b/valid%0b/%h exp=0/1/0/0/%h",
                           count, empty, overflow_err, instr_valid_id, instruction_id, NOP);
    end
    riscv_v_stall = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    riscv_v_stall = 1'b0;
    for (int k = 0; k < 12; k++) begin
      enq_valid = 1'b1; enq_instr = 32'h3000_0057 + k; enq_int_data = 32'h50 + k;
      #1;
      checks++; if (count > 3'd1) begin failures++; $display("FAIL stream_count%0d got=%0d exp<=1", k, count); end
`ifdef RISCV_V_ISSUE_BYPASS_EN
      checks++; if (instruction_id !== 32'h3000_0057 + k || instr_valid_id !== 1'b1) begin
        failures++; $display("FAIL stream_head%0d got=%h/%0b exp=%h/1", k, instruction_id, instr_valid_id, 32'h3000_0057 + k);
      end
`else
      if (k > 0) begin
        checks++; if (instruction_id !== 32'h3000_0057 + k - 1 || int_rf_rd_data_id !== 32'h50 + k - 1) begin
          failures++; $display("FAIL stream_head%0d got=%h/%h exp=%h/%h", k, instruction_id, int_rf_rd_data_id,
                               32'h3000_0057 + k - 1, 32'h50 + k - 1);
        end
      end
`endif
      tick();
    end
    enq_valid = 1'b0;
    #1;
`ifndef RISCV_V_ISSUE_BYPASS_EN
    checks++; if (instruction_id !== 32'h3000_0062) begin failures++; $display("FAIL stream_last got=%h exp=30000062", instruction_id); end
    tick();
`endif
    checks++; if (empty !== 1'b1 || instr_valid_id !== 1'b0) begin failures++; $display("FAIL stream_end got=%0b/%0b exp=1/0", empty, instr_valid_id); end
  endtask

  task automatic test_flush();
    do_reset();
    riscv_v_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      enq_valid = 1'b1; enq_instr = 32'h4000_0057 + k; enq_int_data = k;
      tick();
    end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    clear_pipe = 1'b1; enq_instr = 32'h4444_0057; enq_int_data = 32'h44;
    tick();
    clear_pipe = 1'b0; enq_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || instr_valid_id !== 1'b0 || instruction_id !== NOP) begin
      failures++; $display("FAIL flush_state got=cnt%0d/valid%0b/%h exp=0/0/%h", count, instr_valid_id, instruction_id, NOP);
    end
    enq_valid = 1'b1; enq_instr = 32'h5000_0057; enq_int_data = 32'h55;
    tick();
    enq_valid = 1'b0;
    #1;
    checks++; if (instruction_id !== 32'h5000_0057 || count !== 3'd1) begin
      failures++; $display("FAIL flush_after got=%h/cnt%0d exp=50000057/1", instruction_id, count);
    end
    riscv_v_stall = 1'b0;
    tick();
  endtask

`ifdef RISCV_V_ISSUE_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    riscv_v_stall = 1'b0; enq_valid = 1'b1; enq_instr = 32'h0200_8057; enq_int_data = 32'h77;
    #1;
    checks++; if (instruction_id !== 32'h0200_8057 || instr_valid_id !== 1'b1 || int_rf_rd_data_id !== 32'h77) begin
      failures++; $display("FAIL bypass_same_cycle got=%h/%0b exp=02008057/1", instruction_id, instr_valid_id);
    end
    tick();
    enq_valid = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL bypass_count got=%0d exp=0", count); end
    riscv_v_stall = 1'b1; enq_valid = 1'b1;
    #1;
    checks++; if (instruction_id !== 32'h0200_8057) begin failures++; $display("FAIL bypass_stall_pres got=%h exp=02008057", instruction_id); end
    tick();
    enq_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd1 || instruction_id !== 32'h0200_8057) begin
      failures++; $display("FAIL bypass_stall_hold got=cnt%0d/%h exp=1/02008057", count, instruction_id);
    end
    riscv_v_stall = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_fill_order();
    test_overflow();
    test_back_to_back();
    test_flush();
`ifdef RISCV_V_ISSUE_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_v_issue_queue.md
# riscv_v_issue_queue

- Buffers vector instructions, with their scalar operand, handed over by the scalar core.
- Presents them in order to the vector decode stage as `instruction_id` / `int_rf_rd_data_id`.
- Sits directly upstream of vector decode:
  - decouples scalar-core issue from vector back-pressure (`riscv_v_stall`);
  - flushes on `clear_pipe`.

## Interface

Parameters:
- `DEPTH`, 4 — number of entries; power of two, ≥2.
- `INSTR_WIDTH`, 32 — instruction width.
- `DATA_WIDTH`, 32 — scalar operand width.
- `NOP_INSTR`, 32'h0000_0013 — value driven on `instruction_id` when no valid instruction is presented.

Ports:
- `clk`  in  1  — clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `clear_pipe`  in  1  — synchronous flush of all entries.
- `enq_valid`  in  1  — scalar core offers an instruction this cycle.
- `enq_instr`  in  INSTR_WIDTH  — offered instruction.
- `enq_int_data`  in  DATA_WIDTH  — scalar rs1 value paired with `enq_instr`.
- `enq_ready`  out  1  — queue accepts this cycle; equals !full.
- `riscv_v_stall`  in  1  — decode stage cannot consume; head is held.
- `instruction_id`  out  INSTR_WIDTH  — head instruction, or NOP_INSTR when nothing is presented.
- `int_rf_rd_data_id`  out  DATA_WIDTH  — head operand, or 0 when nothing is presented.
- `instr_valid_id`  out  1  — head presented is a real instruction.
- `count`  out  $clog2(DEPTH+1)  — occupancy.
- `full`  out  1  — count == DEPTH.
- `empty`  out  1  — count == 0.
- `overflow_err`  out  1  — sticky; set when `enq_valid` is asserted while full.

## Operation

- Storage:
  - circular buffer of {instr, data};
  - write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits, wrap modulo DEPTH;
  - `count` is held as a separate register.
- Enqueue (`enq`) = `enq_valid && enq_ready`:
  - writes the entry at `wp`, then `wp++`.
- Dequeue (`deq`) = `instr_valid_id && !riscv_v_stall`:
  - `rp++`.
- Count update:
  - enq only: +1;
  - deq only: −1;
  - both, or neither: unchanged.
- `enq_ready` depends only on registered `count`. When full, an offer is refused even if a dequeue occurs in the same cycle; it is accepted the following cycle.
- Refused offer (`enq_valid && full`):
  - instruction dropped;
  - `overflow_err` set to 1;
  - the scalar core is expected to have honoured `enq_ready`.
- Head outputs:
  - not empty: `instruction_id`, `int_rf_rd_data_id` = entry[rp], `instr_valid_id` = 1;
  - empty (no bypass): NOP_INSTR / 0 / 0.
- Priority per edge: `rst` > `clear_pipe` > enq/deq.
- `clear_pipe`:
  - `wp`, `rp`, `count` go to 0;
  - a same-cycle enqueue is discarded;
  - `overflow_err` is kept.
- Reset values:
  - `wp` = `rp` = `count` = 0, `overflow_err` = 0;
  - hence `empty` = 1, `full` = 0, `enq_ready` = 1, `instr_valid_id` = 0, `instruction_id` = NOP_INSTR, `int_rf_rd_data_id` = 0.
- Storage array is not reset.
- In-order delivery: no reordering, no duplication.
- Stall hold: while `riscv_v_stall` = 1, the head outputs stay bit-stable.

## Timing

- Enqueue-to-present latency:
  - 1 cycle without bypass: an instruction accepted at edge N appears on `instruction_id` in the cycle after edge N.
  - 0 cycles with bypass (see Configuration).
- Throughput: 1 enqueue + 1 dequeue per cycle sustained, at any occupancy below DEPTH.
- `count`, `full`, `empty`, `enq_ready` are registered-state derived, with no combinational path from `enq_valid`.
- Mid-operation reset: a reset during a stall or while full empties the queue on that edge, and the next cycle matches the reset values.
- Pointer wrap: `wp`/`rp` roll over DEPTH−1 → 0 with no bubble.

## Configuration

- Macro: `RISCV_V_ISSUE_BYPASS_EN`.
- Defined (bypass compiled in):
  - when `empty` && `enq_valid` && !`clear_pipe`, the head outputs combinationally present `enq_instr` / `enq_int_data` with `instr_valid_id` = 1;
  - if `riscv_v_stall` = 0 the entry is consumed without being written (`count` stays 0);
  - if `riscv_v_stall` = 1 it is written normally and held.
- Undefined: head outputs are driven only from storage; latency 1 cycle; no `enq_*` → `*_id` combinational path.

## Test plan

- Reset: assert `rst` 2 cycles → `empty`=1, `count`=0, `enq_ready`=1, `instruction_id`=32'h0000_0013, `instr_valid_id`=0, `overflow_err`=0.
- Fill and order: 4 enqueues (instr 32'h0000_1057+k, data k) with stall=1 → `full`=1, `enq_ready`=0; release stall → heads 0..3 emitted in 4 consecutive cycles, then `empty`=1.
- Overflow: full, `enq_valid`=1 with `enq_instr`=32'hDEAD_0057 → entry dropped, `count` stays 4, `overflow_err`=1 until `rst`. Same cycle with deq → still refused, accepted next cycle.
- Wrap/streaming: 12 back-to-back enq with no stall → each instruction delivered once, in order; `count` ≤1 (without bypass, 1-cycle latency); pointers wrap 3 times.
- Flush: `count`=3 and `clear_pipe`=1 with simultaneous enq → next cycle `count`=0, `instr_valid_id`=0, enqueued instruction absent.
- Bypass (macro defined): empty, enq 32'h0200_8057, stall=0 → `instruction_id`=32'h0200_8057 same cycle, `count` stays 0. With stall=1 → `count`=1 and head held.
